// File: rtl/bdr_pkg.sv
// Shared constants for the parametrised register bank: default geometry and the
// address that reads as zero.
package bdr_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int BYTES      = DEF_DATA_W / 8;
   localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/bdr_if.sv
// Decode/writeback bus of the register bank: two read addresses and data,
// two retire lanes with byte enables, and the same-register write flag.
interface bdr_if
   import bdr_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic [ADDR_W-1:0]   RR1;
   logic [ADDR_W-1:0]   RR2;
   logic [ADDR_W-1:0]   WriteRg0;
   logic [DATA_W-1:0]   WriteData0;
   logic                RegWrite0;
   logic [DATA_W/8-1:0] ByteEn0;
   logic [ADDR_W-1:0]   WriteRg1;
   logic [DATA_W-1:0]   WriteData1;
   logic                RegWrite1;
   logic [DATA_W/8-1:0] ByteEn1;
   logic [DATA_W-1:0]   RD1;
   logic [DATA_W-1:0]   RD2;
   logic                WrConflict;

   modport master (
      output RR1, RR2,
      output WriteRg0, WriteData0, RegWrite0, ByteEn0,
      output WriteRg1, WriteData1, RegWrite1, ByteEn1,
      input  RD1, RD2, WrConflict
   );

   modport slave (
      input  RR1, RR2,
      input  WriteRg0, WriteData0, RegWrite0, ByteEn0,
      input  WriteRg1, WriteData1, RegWrite1, ByteEn1,
      output RD1, RD2, WrConflict
   );
endinterface

// File: rtl/bdr_byte_merge.sv
// Byte-wise merge of two write lanes over an old word; lane 1 wins on bytes
// both lanes enable. Shared by the storage rows and the read bypass.
module bdr_byte_merge
   import bdr_pkg::*;
#(
   parameter int NBYTES = BYTES
) (
   input  logic [NBYTES*8-1:0] old_word,
   input  logic [NBYTES*8-1:0] data0,
   input  logic [NBYTES-1:0]   be0,
   input  logic                hit0,
   input  logic [NBYTES*8-1:0] data1,
   input  logic [NBYTES-1:0]   be1,
   input  logic                hit1,
   output logic [NBYTES*8-1:0] merged
);
   always_comb begin
      merged = old_word;
      for (int i = 0; i < NBYTES; i++) begin
         if (hit0 && be0[i]) merged[8*i +: 8] = data0[8*i +: 8];
         if (hit1 && be1[i]) merged[8*i +: 8] = data1[8*i +: 8];
      end
   end
endmodule

// File: rtl/banco_registros_param.sv
// Two-read / two-write register bank with per-byte enables, write-first bypass,
// optional hardwired-zero register 0 and optional registered read ports.
module banco_registros_param
   import bdr_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int READ_LAT = 0,
   parameter int ZERO_R0  = 1
) (
   input logic clk,
   input logic rst,
   bdr_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NB    = DATA_W / 8;

   logic [DATA_W-1:0] regs     [0:DEPTH-1];
   logic [DATA_W-1:0] row_next [0:DEPTH-1];
   logic              wr0_en, wr1_en, conflict_p0;
   logic              zero0, zero1;
   logic [DATA_W-1:0] rd1_p0, rd2_p0, rd1_p1, rd2_p1;
   logic              conflict_p1;

   // A lane only writes when some byte is enabled and the target is not the zero register.
   assign zero0       = (ZERO_R0 != 0) && (bus.WriteRg0 == ADDR_W'(ZERO_ADDR));
   assign zero1       = (ZERO_R0 != 0) && (bus.WriteRg1 == ADDR_W'(ZERO_ADDR));
   assign wr0_en      = bus.RegWrite0 && (|bus.ByteEn0) && !zero0;
   assign wr1_en      = bus.RegWrite1 && (|bus.ByteEn1) && !zero1;
   assign conflict_p0 = wr0_en && wr1_en && (bus.WriteRg0 == bus.WriteRg1);

   for (genvar r = 0; r < DEPTH; r++) begin : g_row
      bdr_byte_merge #(.NBYTES(NB)) u_merge (
         .old_word (regs[r]),
         .data0    (bus.WriteData0),
         .be0      (bus.ByteEn0),
         .hit0     (wr0_en && (bus.WriteRg0 == ADDR_W'(r))),
         .data1    (bus.WriteData1),
         .be1      (bus.ByteEn1),
         .hit1     (wr1_en && (bus.WriteRg1 == ADDR_W'(r))),
         .merged   (row_next[r])
      );
   end

   // Stage p0: write-first bypass on each read port.
   bdr_byte_merge #(.NBYTES(NB)) u_byp1 (
      .old_word (regs[bus.RR1]),
      .data0    (bus.WriteData0),
      .be0      (bus.ByteEn0),
      .hit0     (wr0_en && (bus.WriteRg0 == bus.RR1)),
      .data1    (bus.WriteData1),
      .be1      (bus.ByteEn1),
      .hit1     (wr1_en && (bus.WriteRg1 == bus.RR1)),
      .merged   (rd1_p0)
   );

   bdr_byte_merge #(.NBYTES(NB)) u_byp2 (
      .old_word (regs[bus.RR2]),
      .data0    (bus.WriteData0),
      .be0      (bus.ByteEn0),
      .hit0     (wr0_en && (bus.WriteRg0 == bus.RR2)),
      .data1    (bus.WriteData1),
      .be1      (bus.ByteEn1),
      .hit1     (wr1_en && (bus.WriteRg1 == bus.RR2)),
      .merged   (rd2_p0)
   );

   // Stage p1: storage, registered read data and conflict flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         rd1_p1      <= '0;
         rd2_p1      <= '0;
         conflict_p1 <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= row_next[i];
         rd1_p1      <= rd1_p0;
         rd2_p1      <= rd2_p0;
         conflict_p1 <= conflict_p0;
      end
   end

   assign bus.RD1        = (READ_LAT != 0) ? rd1_p1 : rd1_p0;
   assign bus.RD2        = (READ_LAT != 0) ? rd2_p1 : rd2_p0;
   assign bus.WrConflict = conflict_p1;
endmodule

// File: tb/tb_banco_registros_param.sv
// Drives a combinational-read and a registered-read bank with identical traffic
// and compares both against an array model of the register file.
module tb_banco_registros_param;
   logic clk = 1'b0;
   logic rst;

   logic [4:0]  rr1, rr2, wa0, wa1;
   logic [31:0] wd0, wd1;
   logic        we0, we1;
   logic [3:0]  be0, be1;

   bdr_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
   bdr_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

   assign bus0.RR1 = rr1;        assign bus1.RR1 = rr1;
   assign bus0.RR2 = rr2;        assign bus1.RR2 = rr2;
   assign bus0.WriteRg0 = wa0;   assign bus1.WriteRg0 = wa0;
   assign bus0.WriteData0 = wd0; assign bus1.WriteData0 = wd0;
   assign bus0.RegWrite0 = we0;  assign bus1.RegWrite0 = we0;
   assign bus0.ByteEn0 = be0;    assign bus1.ByteEn0 = be0;
   assign bus0.WriteRg1 = wa1;   assign bus1.WriteRg1 = wa1;
   assign bus0.WriteData1 = wd1; assign bus1.WriteData1 = wd1;
   assign bus0.RegWrite1 = we1;  assign bus1.RegWrite1 = we1;
   assign bus0.ByteEn1 = be1;    assign bus1.ByteEn1 = be1;

   banco_registros_param #(.DATA_W(32), .ADDR_W(5), .READ_LAT(0), .ZERO_R0(1)) u_lat0 (
      .clk (clk), .rst (rst), .bus (bus0)
   );
   banco_registros_param #(.DATA_W(32), .ADDR_W(5), .READ_LAT(1), .ZERO_R0(1)) u_lat1 (
      .clk (clk), .rst (rst), .bus (bus1)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:31];
   logic [31:0] e1_q, e2_q;
   logic        conf_q;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] expand(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   // Value of register a as seen this cycle, including this cycle's writes.
   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic [31:0] v, m;
      if (a == 5'd0) return 32'h0;
      v = mem[a];
      if (we0 && wa0 == a) begin m = expand(be0); v = (v & ~m) | (wd0 & m); end
      if (we1 && wa1 == a) begin m = expand(be1); v = (v & ~m) | (wd1 & m); end
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      e1_q = 32'h0;
      e2_q = 32'h0;
      conf_q = 1'b0;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; be0 = 4'h0; be1 = 4'h0;
      wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h0; wd1 = 32'h0;
   endtask

   task automatic sample();
      @(negedge clk);
      chk("l0_rd1", bus0.RD1, model_read(rr1));
      chk("l0_rd2", bus0.RD2, model_read(rr2));
      chk("l1_rd1", bus1.RD1, e1_q);
      chk("l1_rd2", bus1.RD2, e2_q);
      chk("l0_conf", {31'b0, bus0.WrConflict}, {31'b0, conf_q});
      chk("l1_conf", {31'b0, bus1.WrConflict}, {31'b0, conf_q});
   endtask

   task automatic tick();
      logic [31:0] n0, n1;
      @(posedge clk);
      if (rst) begin
         clear_model();
      end else begin
         e1_q   = model_read(rr1);
         e2_q   = model_read(rr2);
         conf_q = we0 && we1 && be0 != 4'h0 && be1 != 4'h0 && wa0 == wa1 && wa0 != 5'd0;
         n0 = model_read(wa0);
         n1 = model_read(wa1);
         if (wa0 != 5'd0) mem[wa0] = n0;
         if (wa1 != 5'd0) mem[wa1] = n1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      clear_model();
      rr1 = 5'd5;
      rr2 = 5'd31;
      sample();
      chk("rst_l1_rd1", bus1.RD1, 32'h0);
      chk("rst_l1_rd2", bus1.RD2, 32'h0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rr1 = 5'd0; rr2 = 5'd0;
      idle();
      clear_model();
      sample();
      tick();
      rst = 1'b0;

      // Test 1: earlier writes are wiped by a mid-run reset.
      we0 = 1'b1; wa0 = 5'd5;  wd0 = 32'h13572468; be0 = 4'hF;
      we1 = 1'b1; wa1 = 5'd31; wd1 = 32'h24681357; be1 = 4'hF;
      sample(); tick();
      idle(); rr1 = 5'd5; rr2 = 5'd31;
      sample(); tick();
      do_reset();
      rr1 = 5'd5; rr2 = 5'd31;
      sample();
      chk("t1_l0_rd1", bus0.RD1, 32'h0);
      chk("t1_l0_rd2", bus0.RD2, 32'h0);
      chk("t1_l1_rd1", bus1.RD1, 32'h0);
      chk("t1_conf", {31'b0, bus0.WrConflict}, 32'h0);
      tick();

      // Test 2: plain lane 0 write, then read.
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAAAAAA; be0 = 4'hF;
      sample(); tick();
      idle(); rr1 = 5'd5; rr2 = 5'd10;
      sample();
      chk("t2_l0_rd1", bus0.RD1, 32'hAAAAAAAA);
      chk("t2_l0_rd2", bus0.RD2, 32'h0);
      tick();
      sample();
      chk("t2_l1_rd1", bus1.RD1, 32'hAAAAAAAA);
      chk("t2_l1_rd2", bus1.RD2, 32'h0);
      tick();

      // Test 3: write-first bypass on lane 1.
      we1 = 1'b1; wa1 = 5'd22; wd1 = 32'hDEADBEEF; be1 = 4'hF;
      rr1 = 5'd22; rr2 = 5'd5;
      sample();
      chk("t3_l0_byp", bus0.RD1, 32'hDEADBEEF);
      chk("t3_l0_rd2", bus0.RD2, 32'hAAAAAAAA);
      tick();
      idle();
      sample();
      chk("t3_l1_byp", bus1.RD1, 32'hDEADBEEF);
      chk("t3_l1_rd2", bus1.RD2, 32'hAAAAAAAA);
      tick();

      // Test 4: both lanes merge into register 7.
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11223344; be0 = 4'hF;
      sample(); tick();
      idle();
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAAAAAA; be0 = 4'h3;
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hBBBBBBBB; be1 = 4'h6;
      rr1 = 5'd7;
      sample();
      chk("t4_l0_byp", bus0.RD1, 32'h11BBBBAA);
      tick();
      idle();
      sample();
      chk("t4_l0_rd1", bus0.RD1, 32'h11BBBBAA);
      chk("t4_l1_rd1", bus1.RD1, 32'h11BBBBAA);
      chk("t4_conf1", {31'b0, bus0.WrConflict}, 32'h1);
      tick();
      sample();
      chk("t4_conf0", {31'b0, bus1.WrConflict}, 32'h0);
      tick();

      // Test 5: register 0 ignores writes, even bypassed.
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; be0 = 4'hF;
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; be1 = 4'hF;
      rr1 = 5'd0;
      sample();
      chk("t5_l0_byp", bus0.RD1, 32'h0);
      tick();
      idle();
      sample();
      chk("t5_l0_rd1", bus0.RD1, 32'h0);
      chk("t5_l1_rd1", bus1.RD1, 32'h0);
      chk("t5_conf", {31'b0, bus0.WrConflict}, 32'h0);
      tick();

      // Test 6: all byte enables clear means no write.
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h12345678; be0 = 4'h0;
      rr1 = 5'd9;
      sample();
      chk("t6_l0_byp", bus0.RD1, 32'h0);
      tick();
      idle();
      sample();
      chk("t6_l0_rd1", bus0.RD1, 32'h0);
      chk("t6_l1_rd1", bus1.RD1, 32'h0);
      tick();

      // Random traffic, biased to a few addresses so lanes collide and bypass often.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 63) == 0) begin
            do_reset();
         end else begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wa1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            be0 = 4'($urandom);
            be1 = 4'($urandom);
            rr1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rr2 = $urandom_range(0, 2) == 0 ? wa1 : 5'($urandom);
            sample();
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
